// File: rtl/ped_crossing_ctrl.sv
// ============================================================================
// Module   : ped_crossing_ctrl
// Function : Pedestrian WALK/DON'T WALK controller fed by the traffic-light FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 10,
    parameter int FLASH_CYCLES = 6,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             ped_wait,
    output logic [CNT_W-1:0] countdown,
    output logic             err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_pend  = 2'd1;
    localparam logic [1:0] c_st_walk  = 2'd2;
    localparam logic [1:0] c_st_flash = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_load  = CNT_W'(WALK_CYCLES + FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_flash_top = CNT_W'(FLASH_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    // Parity of the countdown on the first FLASH cycle, where walk must read 0.
    localparam logic             c_flash_ph  = ((FLASH_CYCLES - 1) % 2) != 0;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_red_q;
    logic             r_err;
    logic             w_legal;
    logic             w_off;
    logic             w_red_rise;

    assign w_legal    = !((red & yellow) | (red & green) | (yellow & green));
    assign w_off      = !(red | yellow | green);
    assign w_red_rise = red & ~r_red_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_red_q <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_red_q <= red;
            if (!w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    // Countdown is zero unless the next state is WALK or FLASH.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        if (!w_legal) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (ped_btn && !w_off) begin
                        w_state_next = c_st_pend;
                    end
                end
                c_st_pend: begin
                    if (w_off) begin
                        w_state_next = c_st_idle;
                    end else if (w_red_rise) begin
                        w_state_next = c_st_walk;
                        w_cnt_next   = c_cnt_load;
                    end
                end
                c_st_walk: begin
                    if (!red) begin
                        w_state_next = c_st_idle;
                    end else begin
                        w_cnt_next = r_cnt - c_cnt_one;
                        if (r_cnt == c_flash_top) begin
                            w_state_next = c_st_flash;
                        end
                    end
                end
                c_st_flash: begin
                    if (!red || (r_cnt == '0)) begin
                        w_state_next = c_st_idle;
                    end else begin
                        w_cnt_next = r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    w_state_next = c_st_idle;
                end
            endcase
        end
    end

    always_comb begin
        walk      = 1'b0;
        dont_walk = 1'b1;
        ped_wait  = 1'b0;
        case (r_state)
            c_st_pend: begin
                ped_wait = 1'b1;
            end
            c_st_walk: begin
                walk      = 1'b1;
                dont_walk = 1'b0;
            end
            c_st_flash: begin
                walk      = r_cnt[0] ^ c_flash_ph;
                dont_walk = 1'b0;
            end
            default: begin
                walk      = 1'b0;
                dont_walk = 1'b1;
            end
        endcase
    end

    assign countdown = r_cnt;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
- Pedestrian crossing controller directly downstream of the traffic-light FSM.
- Consumes the FSM's one-hot red/yellow/green lamp outputs and a pedestrian push-button.
- Drives the WALK / DON'T WALK signal heads, a request-pending lamp and a countdown display.
- Grants WALK only at the start of a red phase and aborts immediately if red drops or the lamp inputs become illegal.

Parameters:
- WALK_CYCLES, 10, clock cycles of steady WALK (min 1).
- FLASH_CYCLES, 6, clock cycles of flashing WALK after steady WALK (min 1).
- CNT_W, 8, countdown width; must hold WALK_CYCLES+FLASH_CYCLES-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- red  input  1  traffic FSM red lamp.
- yellow  input  1  traffic FSM yellow lamp.
- green  input  1  traffic FSM green lamp.
- ped_btn  input  1  pedestrian push-button, level, already debounced.
- walk  output  1  WALK lamp.
- dont_walk  output  1  DON'T WALK lamp.
- ped_wait  output  1  "request pending" lamp.
- countdown  output  CNT_W  remaining WALK+FLASH cycles; 0 outside WALK/FLASH.
- err  output  1  sticky illegal-lamp-input flag.

Behaviour:
- Lamp decode:
  - legal = at most one of red/yellow/green high.
  - off = all three low.
- Reset, all registered outputs: walk=0, dont_walk=1, ped_wait=0, countdown=0, err=0, state=IDLE, red_q=0.
- red_q: red registered every cycle; red_rise = red & ~red_q.
- States:
  - IDLE: dont_walk=1, walk=0.
  - PEND: dont_walk=1, ped_wait=1.
  - WALK: walk=1, dont_walk=0.
  - FLASH: dont_walk=0, walk toggles.
- IDLE -> PEND: ped_btn=1 while legal and not off. ped_wait=1 from the next edge.
- PEND -> WALK: on red_rise.
  - Latency: red rises before edge N, so walk=1 and dont_walk=0 from edge N.
  - ped_wait clears at the same edge.
  - countdown loads WALK_CYCLES+FLASH_CYCLES-1 at the same edge.
- Grant rules:
  - A request made while red is already steady high waits for the next red_rise; no mid-red grant.
  - A request made in the same cycle as red_rise (from IDLE) goes to PEND only; it is not granted that cycle.
- WALK -> FLASH: after exactly WALK_CYCLES cycles in WALK.
- FLASH:
  - Lasts FLASH_CYCLES cycles.
  - walk=0 on the 1st FLASH cycle, 1 on the 2nd, alternating.
  - Then -> IDLE with dont_walk=1 and countdown=0.
- countdown:
  - Decrements by 1 every cycle in WALK/FLASH.
  - Reads 0 on the last FLASH cycle.
  - Never wraps; held at 0 in IDLE/PEND.
- Requests during WALK/FLASH: ignored, not latched.
  - A button held through the end of FLASH re-enters PEND on the cycle after IDLE is reached.
- Abort (priority over all transitions except reset): in WALK or FLASH, if red=0 or !legal:
  - next edge -> IDLE, walk=0, dont_walk=1, countdown=0, ped_wait=0.
- Traffic off (off=1) in PEND: request cancelled, -> IDLE, ped_wait=0.
- Illegal input (!legal) in any state:
  - err=1 (sticky until reset), state forced to IDLE, dont_walk=1.
  - New requests are blocked while !legal.
- Reset mid-operation: next edge restores all reset values regardless of state or inputs.
- Invariant, checked by bench assertion: walk and dont_walk are never both 1; dont_walk=0 only while red=1 was seen at entry and remains 1.

Test Plan:
- Bench overrides WALK_CYCLES=4, FLASH_CYCLES=4.
- Reset: reset=1 for 2 cycles with red=1, ped_btn=1 -> dont_walk=1, walk=0, ped_wait=0, countdown=0, err=0 on every edge while reset=1.
- Normal grant: green=1, pulse ped_btn 1 cycle -> ped_wait=1 next edge. Then yellow, then red rises -> from that edge:
  - walk=1 for 4 cycles, countdown 7,6,5,4.
  - FLASH: walk 0,1,0,1, countdown 3,2,1,0.
  - Then dont_walk=1, ped_wait=0.
- Mid-red request: ped_btn while red steady high -> no WALK in that red phase; ped_wait stays 1 through green/yellow; WALK starts at the next red_rise.
- Abort: during WALK cycle 2 drive red=0, green=1 -> next edge walk=0, dont_walk=1, countdown=0, state IDLE, err=0.
- Traffic off and illegal input:
  - In PEND drive all lamps 0 -> ped_wait=0 next edge, no WALK on the later red_rise.
  - Drive red=1 and green=1 together -> err=1, dont_walk=1; err stays 1 after legal inputs return until reset.
- Held button: ped_btn held high through a full grant -> PEND re-entered 1 cycle after FLASH ends; second WALK only at the next red_rise.
